// File: rtl/pwl_inverse.sv
// Inverse piecewise-linear lookup: given an ordinate q, return the abscissa x
// such that the loaded breakpoint curve passes through (x, q). Interior points
// are interpolated with a multiply followed by a 16-step restoring divide.
//
// state  | meaning
// -------+---------------------------------------------------------------
// LOAD   | accepting breakpoint pairs, index cnt
// IDLE   | table valid, waiting for a query (or tbl_clr)
// SEARCH | locate query against table, resolve clamps and exact hits
// MUL    | form dq*dx and seed the divider
// DIV    | one quotient bit per cycle, MSB first, 16 cycles
// OUT    | result held until r_ready
module pwl_inverse #(
  parameter int NPTS = 4,
  parameter int FRAC = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_x,
  input  logic [15:0] load_v,
  input  logic        tbl_clr,
  output logic        tbl_err,
  input  logic        q_valid,
  output logic        q_ready,
  input  logic [15:0] q_v,
  output logic        r_valid,
  input  logic        r_ready,
  output logic [15:0] r_x,
  output logic        r_err
);

  localparam int CW = $clog2(NPTS);

  // Format is only informational; reject nonsense parameterisations early.
  if (NPTS < 2 || NPTS > 8 || FRAC < 0 || FRAC > 16) begin : g_param_chk
    $error("pwl_inverse: illegal NPTS/FRAC");
  end

  typedef enum logic [2:0] {
    S_LOAD, S_IDLE, S_SEARCH, S_MUL, S_DIV, S_OUT
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [15:0]     x_q [NPTS];
  logic [15:0]     v_q [NPTS];
  logic [15:0]     q_q;
  logic            tbl_err_q;
  logic [15:0]     r_x_q;
  logic            r_err_q;
  logic [15:0]     xi_q, dx_q, dv_q, dq_q;
  logic [15:0]     rem_q, sh_q, quo_q;
  logic [3:0]      step_q;

  logic            err_d;
  logic [15:0]     chk_x [NPTS];
  logic [15:0]     chk_v [NPTS];
  logic            hit_eq;
  logic [CW-1:0]   eq_idx, seg_idx;
  logic [31:0]     prod;
  logic [16:0]     div_t;
  logic            div_ge;
  logic [15:0]     div_rem;
  logic [15:0]     quo_nxt;

  assign load_ready = (state_q == S_LOAD);
  assign q_ready    = (state_q == S_IDLE);
  assign r_valid    = (state_q == S_OUT);
  assign tbl_err    = tbl_err_q;
  assign r_x        = r_x_q;
  assign r_err      = r_err_q;

  // Monotonicity check over the table as it will look once the final pair lands.
  always_comb begin
    err_d = 1'b0;
    for (int k = 0; k < NPTS; k++) begin
      chk_x[k] = x_q[k];
      chk_v[k] = v_q[k];
    end
    chk_x[NPTS-1] = load_x;
    chk_v[NPTS-1] = load_v;
    for (int k = 0; k < NPTS - 1; k++) begin
      if (chk_x[k+1] <= chk_x[k] || chk_v[k+1] <= chk_v[k]) err_d = 1'b1;
    end
  end

  // Exact-hit and bracketing-segment search against the latched query.
  always_comb begin
    hit_eq  = 1'b0;
    eq_idx  = '0;
    seg_idx = '0;
    for (int k = 0; k < NPTS; k++) begin
      if (!hit_eq && q_q == v_q[k]) begin
        hit_eq = 1'b1;
        eq_idx = CW'(k);
      end
    end
    for (int k = 0; k < NPTS - 1; k++) begin
      if (q_q > v_q[k] && q_q < v_q[k+1]) seg_idx = CW'(k);
    end
  end

  // Product and one restoring-divide step; the remainder stays below dv.
  always_comb begin
    prod    = 32'(dq_q) * 32'(dx_q);
    div_t   = {rem_q, sh_q[15]};
    div_ge  = (div_t >= {1'b0, dv_q});
    div_rem = div_ge ? 16'(div_t - {1'b0, dv_q}) : div_t[15:0];
    quo_nxt = {quo_q[14:0], div_ge};
  end

  // Control FSM, table storage and registered result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_LOAD;
      cnt_q     <= '0;
      tbl_err_q <= 1'b0;
      r_x_q     <= '0;
      r_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (load_valid) begin
            x_q[cnt_q] <= load_x;
            v_q[cnt_q] <= load_v;
            if (cnt_q == CW'(NPTS - 1)) begin
              cnt_q     <= '0;
              tbl_err_q <= err_d;
              state_q   <= S_IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_IDLE: begin
          if (q_valid) begin
            q_q     <= q_v;
            state_q <= S_SEARCH;
          end else if (tbl_clr) begin
            cnt_q     <= '0;
            tbl_err_q <= 1'b0;
            state_q   <= S_LOAD;
          end
        end
        S_SEARCH: begin
          if (tbl_err_q) begin
            r_x_q   <= '0;
            r_err_q <= 1'b1;
            state_q <= S_OUT;
          end else if (q_q < v_q[0]) begin
            r_x_q   <= x_q[0];
            r_err_q <= 1'b1;
            state_q <= S_OUT;
          end else if (q_q > v_q[NPTS-1]) begin
            r_x_q   <= x_q[NPTS-1];
            r_err_q <= 1'b1;
            state_q <= S_OUT;
          end else if (hit_eq) begin
            r_x_q   <= x_q[eq_idx];
            r_err_q <= 1'b0;
            state_q <= S_OUT;
          end else begin
            xi_q    <= x_q[seg_idx];
            dx_q    <= x_q[seg_idx + 1'b1] - x_q[seg_idx];
            dv_q    <= v_q[seg_idx + 1'b1] - v_q[seg_idx];
            dq_q    <= q_q - v_q[seg_idx];
            state_q <= S_MUL;
          end
        end
        S_MUL: begin
          // dq < dv guarantees the upper half is already a valid remainder.
          rem_q   <= prod[31:16];
          sh_q    <= prod[15:0];
          quo_q   <= '0;
          step_q  <= 4'd15;
          state_q <= S_DIV;
        end
        S_DIV: begin
          rem_q <= div_rem;
          sh_q  <= {sh_q[14:0], 1'b0};
          quo_q <= quo_nxt;
          if (step_q == 4'd0) begin
            r_x_q   <= xi_q + quo_nxt;
            r_err_q <= 1'b0;
            state_q <= S_OUT;
          end else begin
            step_q <= step_q - 1'b1;
          end
        end
        S_OUT: begin
          if (r_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_pwl_inverse.sv
// Directed bench for pwl_inverse with hand-computed expected results.
module tb_pwl_inverse;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_x = '0;
  logic [15:0] load_v = '0;
  logic        tbl_clr = 1'b0;
  logic        tbl_err;
  logic        q_valid = 1'b0;
  logic        q_ready;
  logic [15:0] q_v = '0;
  logic        r_valid;
  logic        r_ready = 1'b0;
  logic [15:0] r_x;
  logic        r_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] tx [4];
  logic [15:0] tv [4];

  pwl_inverse #(.NPTS(4), .FRAC(8)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_x(load_x), .load_v(load_v),
    .tbl_clr(tbl_clr), .tbl_err(tbl_err),
    .q_valid(q_valid), .q_ready(q_ready), .q_v(q_v),
    .r_valid(r_valid), .r_ready(r_ready),
    .r_x(r_x), .r_err(r_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tbl(input logic [15:0] x0, x1, x2, x3, v0, v1, v2, v3);
    tx[0] = x0; tx[1] = x1; tx[2] = x2; tx[3] = x3;
    tv[0] = v0; tv[1] = v1; tv[2] = v2; tv[3] = v3;
  endtask

  task automatic load_tbl(input string tag);
    int n;
    for (int k = 0; k < 4; k++) begin
      load_x = tx[k];
      load_v = tv[k];
      load_valid = 1'b1;
      n = 0;
      while (!load_ready && n < 50) begin
        tick();
        n++;
      end
      chk({tag, "_lrdy"}, 32'(load_ready), 32'd1);
      tick();
    end
    load_valid = 1'b0;
  endtask

  task automatic do_query(input string tag, input logic [15:0] qv, input logic [15:0] ex,
                          input logic ee, input int elat, input int stall, input logic clr);
    int n;
    int lat;
    q_v = qv;
    q_valid = 1'b1;
    tbl_clr = clr;
    n = 0;
    while (!q_ready && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_qrdy"}, 32'(q_ready), 32'd1);
    tick();
    q_valid = 1'b0;
    tbl_clr = 1'b0;
    lat = 0;
    while (!r_valid && lat < 100) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(elat));
    chk({tag, "_rx"}, 32'(r_x), 32'(ex));
    chk({tag, "_rerr"}, 32'(r_err), 32'(ee));
    for (int s = 0; s < stall; s++) begin
      tick();
      chk({tag, "_stall_rx"}, 32'(r_x), 32'(ex));
      chk({tag, "_stall_qrdy"}, 32'(q_ready), 32'd0);
      chk({tag, "_stall_rv"}, 32'(r_valid), 32'd1);
    end
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    chk({tag, "_done_rv"}, 32'(r_valid), 32'd0);
    chk({tag, "_done_qrdy"}, 32'(q_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b0;
    tick();
    tick();
    chk("rst_lrdy", 32'(load_ready), 32'd1);
    chk("rst_qrdy", 32'(q_ready), 32'd0);
    chk("rst_rv", 32'(r_valid), 32'd0);
    chk("rst_rx", 32'(r_x), 32'd0);
    chk("rst_rerr", 32'(r_err), 32'd0);
    chk("rst_terr", 32'(tbl_err), 32'd0);
    rst = 1'b1;
    tick();

    // Table A
    set_tbl(16'h0000, 16'h0100, 16'h0200, 16'h0400, 16'h0000, 16'h0200, 16'h0300, 16'h0600);
    load_tbl("ldA");
    chk("ldA_terr", 32'(tbl_err), 32'd0);
    chk("ldA_lrdy0", 32'(load_ready), 32'd0);
    do_query("qA_100", 16'h0100, 16'h0080, 1'b0, 18, 10, 1'b0);
    do_query("qA_480", 16'h0480, 16'h0300, 1'b0, 18, 0, 1'b0);
    do_query("qA_300", 16'h0300, 16'h0200, 1'b0, 1, 0, 1'b0);
    do_query("qA_700", 16'h0700, 16'h0400, 1'b1, 1, 0, 1'b0);
    do_query("qA_600", 16'h0600, 16'h0400, 1'b0, 1, 0, 1'b0);
    do_query("qA_000", 16'h0000, 16'h0000, 1'b0, 1, 0, 1'b0);

    // Query wins over a simultaneous tbl_clr; table must survive.
    do_query("qA_clr", 16'h0100, 16'h0080, 1'b0, 18, 0, 1'b1);
    chk("clrq_lrdy", 32'(load_ready), 32'd0);
    do_query("qA_keep", 16'h0480, 16'h0300, 1'b0, 18, 0, 1'b0);

    // tbl_clr alone returns to LOAD
    tbl_clr = 1'b1;
    tick();
    tbl_clr = 1'b0;
    chk("clr_lrdy", 32'(load_ready), 32'd1);
    chk("clr_qrdy", 32'(q_ready), 32'd0);

    // Table B: nonzero v0, exercises low clamp and truncation
    set_tbl(16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h0100, 16'h0200, 16'h0300, 16'h0400);
    load_tbl("ldB");
    chk("ldB_terr", 32'(tbl_err), 32'd0);
    do_query("qB_080", 16'h0080, 16'h0010, 1'b1, 1, 0, 1'b0);
    do_query("qB_250", 16'h0250, 16'h0025, 1'b0, 18, 0, 1'b0);
    do_query("qB_218", 16'h0218, 16'h0021, 1'b0, 18, 0, 1'b0);
    do_query("qB_3ff", 16'h03FF, 16'h003F, 1'b0, 18, 0, 1'b0);

    // Non-monotonic table
    tbl_clr = 1'b1;
    tick();
    tbl_clr = 1'b0;
    set_tbl(16'h0000, 16'h0100, 16'h0200, 16'h0400, 16'h0000, 16'h0200, 16'h0200, 16'h0600);
    load_tbl("ldE");
    chk("ldE_terr", 32'(tbl_err), 32'd1);
    do_query("qE_100", 16'h0100, 16'h0000, 1'b1, 1, 0, 1'b0);
    tbl_clr = 1'b1;
    tick();
    tbl_clr = 1'b0;
    chk("clrE_terr", 32'(tbl_err), 32'd0);
    chk("clrE_lrdy", 32'(load_ready), 32'd1);

    // Reset in the middle of DIV
    set_tbl(16'h0000, 16'h0100, 16'h0200, 16'h0400, 16'h0000, 16'h0200, 16'h0300, 16'h0600);
    load_tbl("ldR");
    q_v = 16'h0100;
    q_valid = 1'b1;
    chk("rdiv_qrdy", 32'(q_ready), 32'd1);
    tick();
    q_valid = 1'b0;
    repeat (8) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rdiv_lrdy", 32'(load_ready), 32'd1);
    chk("rdiv_rv", 32'(r_valid), 32'd0);
    chk("rdiv_terr", 32'(tbl_err), 32'd0);
    chk("rdiv_qrdy0", 32'(q_ready), 32'd0);
    chk("rdiv_rx", 32'(r_x), 32'd0);
    repeat (20) tick();
    chk("rdiv_quiet_rv", 32'(r_valid), 32'd0);
    chk("rdiv_quiet_lrdy", 32'(load_ready), 32'd1);
    load_tbl("ldR2");
    do_query("qR_100", 16'h0100, 16'h0080, 1'b0, 18, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
